dsp_pipe_stage_chain: RTL and testbench

- Parametrised successor to the single-stage DSP pipeline register with bypass.
- Provides a chain of DEPTH registered stages carrying WIDTH-bit samples with per-stage valid tags and a valid/ready handshake.
- Bubbles collapse under backpressure; a flush clears the chain; an occupancy count is exposed.
- Sits between DSP datapath slices (pre-adder, multiplier, post-adder) wherever stall-tolerant, depth-configurable pipelining is needed.

---
 rtl/dsp_pipe_stage_chain.sv | 110 +++++++++++
 tb/tb_dsp_pipe_stage_chain.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_stage_chain.sv
// dsp_pipe_stage_chain
// DEPTH registered stages of WIDTH-bit samples with per-stage valid tags and a
// valid/ready handshake. Under backpressure, bubbles collapse toward the output.
// Flush clears every valid tag. Occupancy is the live count of valid stages.
// DEPTH=0 degenerates to a purely combinational bypass.
module dsp_pipe_stage_chain #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  occupancy
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};

            assign out_valid = in_valid & ~flush;
            assign out_data  = in_data;
            assign in_ready  = out_ready & ~flush;
            assign occupancy = '0;
        end else begin : g_chain
            logic [DEPTH-1:0] v_q, v_d;
            logic [WIDTH-1:0] d_q [DEPTH];
            logic [WIDTH-1:0] d_d [DEPTH];
            logic [DEPTH-1:0] adv;
            logic             push;
            logic [CNTW-1:0]  occ;

            // Stage advance from the output side. A stage is blocked only when
            // it and every stage in front of it are valid and the sink stalls.
            // Tracking that as a running AND avoids a comb self-loop on adv.
            always_comb begin : p_adv
                logic blocked;
                adv     = '0;
                blocked = ~out_ready;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    blocked = blocked & v_q[i];
                    adv[i]  = ~blocked;
                end
            end

            // in_ready depends only on stage state, out_ready and flush.
            // It never depends on in_valid.
            assign in_ready = adv[0] & ~flush;
            assign push     = in_valid & in_ready;

            // Next-state logic for the stages. Flush wins over any advance
            // and leaves the data registers alone.
            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (flush) begin
                    v_d = '0;
                end else begin
                    if (adv[0]) begin
                        v_d[0] = push;
                        if (push) begin
                            d_d[0] = in_data;
                        end
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        if (adv[i]) begin
                            v_d[i] = v_q[i-1];
                            if (v_q[i-1]) begin
                                d_d[i] = d_q[i-1];
                            end
                        end
                    end
                end
            end

            // Count of valid stages.
            always_comb begin
                occ = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    occ = occ + CNTW'(v_q[i]);
                end
            end

            // Stage registers. Reset clears both the data and the valid tags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            assign out_valid = v_q[DEPTH-1] & ~flush;
            assign out_data  = d_q[DEPTH-1];
            assign occupancy = occ;
        end
    endgenerate

endmodule

// File: tb/tb_dsp_pipe_stage_chain.sv
// Testbench for dsp_pipe_stage_chain: three chained instances (DEPTH 2, 3, 4)
// and one bypass instance (DEPTH 0). All instances share the same stimulus.
// The reference model keeps each chain as an ordered list of in-flight samples
// with their stage positions, oldest sample first.
module tb_dsp_pipe_stage_chain;
    localparam int W  = 18;
    localparam int NI = 3;
    localparam int DEP [NI] = '{2, 3, 4};

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic         ir  [NI];
    logic         ov  [NI];
    logic [W-1:0] od  [NI];
    logic [4:0]   occ [NI];

    logic         ir0, ov0;
    logic [W-1:0] od0;
    logic [4:0]   occ0;

    int checks = 0;
    int errors = 0;

    // Reference model state: sample data and stage position, oldest first.
    logic [W-1:0] m_d    [NI][16];
    int           m_p    [NI][16];
    int           m_np   [NI][16];
    int           m_n    [NI];
    logic [W-1:0] m_last [NI];

    always #5 clk = ~clk;

    dsp_pipe_stage_chain #(.WIDTH(W), .DEPTH(2), .CNTW(5)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]));
    dsp_pipe_stage_chain #(.WIDTH(W), .DEPTH(3), .CNTW(5)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]));
    dsp_pipe_stage_chain #(.WIDTH(W), .DEPTH(4), .CNTW(5)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]));
    dsp_pipe_stage_chain #(.WIDTH(W), .DEPTH(0), .CNTW(5)) u_d0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_n[k]    = 0;
            m_last[k] = '0;
        end
    endtask

    // Where every in-flight sample lands at the next edge (ignoring flush).
    // A value of DEP means the sample leaves through the output.
    task automatic plan(input int k);
        int d, ahead, p;
        d     = DEP[k];
        ahead = d + 1;
        for (int j = 0; j < m_n[k]; j++) begin
            p = m_p[k][j];
            if (p == d - 1) m_np[k][j] = out_ready ? d : d - 1;
            else            m_np[k][j] = (ahead > p + 1) ? p + 1 : p;
            ahead = m_np[k][j];
        end
    endtask

    function automatic bit exp_ready(input int k);
        return !flush && (m_n[k] == 0 || m_np[k][m_n[k]-1] != 0);
    endfunction

    function automatic bit exp_valid(input int k);
        return !flush && m_n[k] > 0 && m_p[k][0] == DEP[k] - 1;
    endfunction

    task automatic step(input int k);
        int d, n2;
        bit acc;
        d = DEP[k];
        if (flush) begin
            m_n[k] = 0;
            return;
        end
        plan(k);
        acc = in_valid && exp_ready(k);
        n2  = 0;
        for (int j = 0; j < m_n[k]; j++) begin
            if (m_np[k][j] < d) begin
                if (m_np[k][j] == d - 1 && m_p[k][j] != d - 1) m_last[k] = m_d[k][j];
                m_d[k][n2] = m_d[k][j];
                m_p[k][n2] = m_np[k][j];
                n2++;
            end
        end
        if (acc) begin
            m_d[k][n2] = in_data;
            m_p[k][n2] = 0;
            if (d == 1) m_last[k] = in_data;
            n2++;
        end
        m_n[k] = n2;
    endtask

    task automatic cycle(input bit iv, input bit ordy, input bit fl, input logic [W-1:0] dat);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = dat;
        #1;
        for (int k = 0; k < NI; k++) begin
            plan(k);
            chk($sformatf("d%0d_occupancy", DEP[k]), 64'(occ[k]), 64'(m_n[k]));
            chk($sformatf("d%0d_out_valid", DEP[k]), 64'(ov[k]), 64'(exp_valid(k)));
            chk($sformatf("d%0d_out_data", DEP[k]), 64'(od[k]), 64'(m_last[k]));
            chk($sformatf("d%0d_in_ready", DEP[k]), 64'(ir[k]), 64'(exp_ready(k)));
        end
        chk("d0_out_valid", 64'(ov0), 64'(iv & ~fl));
        chk("d0_out_data", 64'(od0), 64'(dat));
        chk("d0_in_ready", 64'(ir0), 64'(ordy & ~fl));
        chk("d0_occupancy", 64'(occ0), 64'(0));
        @(posedge clk);
        for (int k = 0; k < NI; k++) step(k);
    endtask

    // Reset asserted between edges must clear the outputs before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("d%0d_rst_out_valid", DEP[k]), 64'(ov[k]), 64'(0));
            chk($sformatf("d%0d_rst_out_data", DEP[k]), 64'(od[k]), 64'(0));
            chk($sformatf("d%0d_rst_occupancy", DEP[k]), 64'(occ[k]), 64'(0));
        end
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int pv, pr;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        #12;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("d%0d_reset_occupancy", DEP[k]), 64'(occ[k]), 64'(0));
            chk($sformatf("d%0d_reset_out_valid", DEP[k]), 64'(ov[k]), 64'(0));
            chk($sformatf("d%0d_reset_out_data", DEP[k]), 64'(od[k]), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        // Streaming at full rate.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 1'b0, 18'(i));
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b1, 1'b0, '0);

        // Fill under backpressure, then pop and push in the same cycle.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 18'h100 + 18'(i));
        cycle(1'b1, 1'b1, 1'b0, 18'h200);
        cycle(1'b1, 1'b0, 1'b0, 18'h201);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Bubble collapse: A, two-cycle gap, B, stall, then release.
        cycle(1'b1, 1'b0, 1'b0, 18'h0AAAA);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 18'h0BBBB);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Flush with two samples in flight and a live input that must be dropped.
        cycle(1'b1, 1'b1, 1'b0, 18'h00011);
        cycle(1'b1, 1'b1, 1'b0, 18'h00022);
        cycle(1'b1, 1'b1, 1'b1, 18'h3FFFF);
        cycle(1'b1, 1'b1, 1'b0, 18'h00033);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Bypass instance with a stalled sink.
        cycle(1'b1, 1'b0, 1'b0, 18'h12345);

        // Randomized traffic, with the backpressure level changing by phase
        // and a mid-stream asynchronous reset.
        for (int i = 0; i < 400; i++) begin
            case ((i / 50) % 4)
                0: begin pv = 80; pr = 90; end
                1: begin pv = 90; pr = 20; end
                2: begin pv = 40; pr = 60; end
                default: begin pv = 70; pr = 50; end
            endcase
            if (i == 210) async_reset();
            cycle($urandom_range(99) < pv, $urandom_range(99) < pr,
                  $urandom_range(99) < 4, 18'($urandom));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
